// File: rtl/me_pkg.sv
// Shared definitions for the Montgomery exponentiation result collector:
// default geometry, the collector state encoding and an index-width helper.
package me_pkg;

    localparam int K_DEF = 128;
    localparam int N_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } me_state_e;

    // Keeps index buses at least one bit wide when a result is a single word.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/me_word_buf.sv
// N x K result word store: one synchronous write port, one asynchronous read port.
// Contents are never reset; every word is rewritten before it is read.
module me_word_buf
    import me_pkg::*;
#(
    parameter int K = K_DEF,
    parameter int N = N_DEF
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [idx_w(N)-1:0]   waddr,
    input  logic [K-1:0]          wdata,
    input  logic [idx_w(N)-1:0]   raddr,
    output logic [K-1:0]          rdata
);

    logic [K-1:0] mem [N];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/me_result_collector.sv
// Collects an N-word result streamed LSW first from the exponentiation core,
// then replays it word by word on a valid/ready output with index and last flags.
module me_result_collector
    import me_pkg::*;
#(
    parameter int K = K_DEF,
    parameter int N = N_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic [K-1:0]          me_result,
    input  logic                  me_valid,
    output logic [K-1:0]          out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [idx_w(N)-1:0]   out_idx,
    output logic                  busy,
    output logic                  overflow
);

    localparam int IW = idx_w(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    me_state_e     state, state_nx;
    logic [IW-1:0] wr_idx, wr_idx_nx;
    logic [IW-1:0] rd_idx, rd_idx_nx;
    logic          overflow_nx;
    logic          buf_we;
    logic [IW-1:0] buf_waddr;
    logic [K-1:0]  buf_rdata;

    me_word_buf #(
        .K (K),
        .N (N)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (buf_waddr),
        .wdata (me_result),
        .raddr (rd_idx),
        .rdata (buf_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_idx   <= '0;
            rd_idx   <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nx;
            wr_idx   <= wr_idx_nx;
            rd_idx   <= rd_idx_nx;
            overflow <= overflow_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        wr_idx_nx   = wr_idx;
        rd_idx_nx   = rd_idx;
        overflow_nx = overflow;
        buf_we      = 1'b0;
        buf_waddr   = wr_idx;

        if (clr) begin
            // Soft clear wins over capture, drain and overflow in the same cycle.
            state_nx    = IDLE;
            wr_idx_nx   = '0;
            rd_idx_nx   = '0;
            overflow_nx = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (me_valid) begin
                        buf_we    = 1'b1;
                        buf_waddr = '0;
                        if (N == 1) begin
                            state_nx  = DRAIN;
                            wr_idx_nx = '0;
                            rd_idx_nx = '0;
                        end else begin
                            state_nx  = FILL;
                            wr_idx_nx = IW'(1);
                        end
                    end
                end
                FILL: begin
                    if (me_valid) begin
                        buf_we = 1'b1;
                        if (wr_idx == LAST_IDX) begin
                            state_nx  = DRAIN;
                            wr_idx_nx = '0;
                            rd_idx_nx = '0;
                        end else begin
                            wr_idx_nx = wr_idx + IW'(1);
                        end
                    end
                end
                DRAIN: begin
                    // Words arriving while the previous result drains are dropped.
                    if (me_valid) begin
                        overflow_nx = 1'b1;
                    end
                    if (out_ready) begin
                        if (rd_idx == LAST_IDX) begin
                            state_nx  = IDLE;
                            rd_idx_nx = '0;
                        end else begin
                            rd_idx_nx = rd_idx + IW'(1);
                        end
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    assign out_valid = (state == DRAIN);
    assign out_data  = out_valid ? buf_rdata : '0;
    assign out_idx   = out_valid ? rd_idx : '0;
    assign out_last  = out_valid && (rd_idx == LAST_IDX);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_me_result_collector.sv
// Scoreboard bench for me_result_collector: stimulus pushes expected output words,
// a negedge monitor pops and compares them on every output handshake.
module tb_me_result_collector;

    localparam int K  = 128;
    localparam int N  = 32;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic [K-1:0]  me_result;
    logic          me_valid;
    logic [K-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [IW-1:0] out_idx;
    logic          busy;
    logic          overflow;

    typedef struct {
        logic [K-1:0]  data;
        logic [IW-1:0] idx;
        logic          last;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          hs_cnt   = 0;
    logic [K*N-1:0] reasm;
    logic [K*N-1:0] big;
    logic          prev_stall = 1'b0;
    logic [K-1:0]  prev_data;
    logic [IW-1:0] prev_idx;

    me_result_collector #(.K(K), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .me_result (me_result),
        .me_valid  (me_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_idx   (out_idx),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [K-1:0] act, input logic [K-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Monitor: output handshakes against the scoreboard, stall stability, idle zeros.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else if (out_valid) begin
            if (prev_stall) begin
                check("stall_data", out_data, prev_data);
                check("stall_idx", K'(out_idx), K'(prev_idx));
            end
            if (out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_word", 1'b1, 1'b0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_idx", K'(out_idx), K'(e.idx));
                    check("out_last", K'(out_last), K'(e.last));
                end
                reasm[out_idx*K +: K] = out_data;
                hs_cnt++;
            end
            prev_stall = !out_ready;
            prev_data  = out_data;
            prev_idx   = out_idx;
        end else begin
            check("idle_data_zero", out_data, '0);
            check("idle_last_zero", K'(out_last), '0);
            prev_stall = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [K-1:0] d);
        me_valid  = 1'b1;
        me_result = d;
        step();
        me_valid  = 1'b0;
        me_result = '0;
    endtask

    // mode 0: values i+1; mode 1: slices of big. Optional 1-cycle gap after each word.
    task automatic send_burst(input int mode, input bit gap, input bit lat_chk);
        for (int i = 0; i < N; i++) begin
            exp_t e;
            e.data = (mode == 0) ? K'(i + 1) : big[i*K +: K];
            e.idx  = IW'(i);
            e.last = (i == N - 1);
            sb_q.push_back(e);
            send_word(e.data);
            if (lat_chk && i == N - 2) check("no_valid_before_last", K'(out_valid), '0);
            if (lat_chk && i == N - 1) check("valid_latency1", K'(out_valid), K'(1));
            if (gap && i != N - 1) begin
                check("gap_no_valid", K'(out_valid), '0);
                step();
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while (busy && c < budget) begin
            step();
            c++;
        end
        check("idle_timeout", K'(busy), '0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, K'(out_valid), '0);
        check({tag, "_last"}, K'(out_last), '0);
        check({tag, "_idx"}, K'(out_idx), '0);
        check({tag, "_data"}, out_data, '0);
        check({tag, "_busy"}, K'(busy), '0);
        check({tag, "_ovf"}, K'(overflow), '0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        rst_n     = 1'b0;
        clr       = 1'b0;
        me_valid  = 1'b0;
        me_result = '0;
        out_ready = 1'b1;
        reasm     = '0;
        for (int i = 0; i < K*N/32; i++) big[i*32 +: 32] = $urandom;
        #23;
        check_zero_outputs("reset");
        rst_n = 1'b1;
        step();

        // Consecutive words 1..32, full-rate consumer.
        send_burst(0, 1'b0, 1'b1);
        wait_idle(100);
        check("sb_empty_t1", K'(sb_q.size()), '0);

        // 4096-bit value, LSW first, reassembled from out_data.
        reasm = '0;
        send_burst(1, 1'b0, 1'b1);
        wait_idle(100);
        n_checks++;
        if (reasm !== big) begin
            n_fail++;
            $display("FAIL reassembly: actual low word %h required %h", reasm[K-1:0], big[K-1:0]);
        end

        // One idle cycle between every word.
        send_burst(0, 1'b1, 1'b1);
        wait_idle(100);
        check("gap_overflow", K'(overflow), '0);

        // Consumer stalled 10 cycles, then toggling ready.
        hs0 = hs_cnt;
        out_ready = 1'b0;
        send_burst(0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step();
        check("stalled_valid", K'(out_valid), K'(1));
        check("stalled_idx", K'(out_idx), '0);
        for (int i = 0; i < 200 && busy; i++) begin
            out_ready = ~out_ready;
            step();
        end
        out_ready = 1'b1;
        wait_idle(10);
        check("stall_hs_total", K'(hs_cnt - hs0), K'(N));

        // Overflow while draining; drained data must be unaffected.
        out_ready = 1'b0;
        send_burst(0, 1'b0, 1'b0);
        send_word(K'(16'hDEAD));
        check("overflow_set", K'(overflow), K'(1));
        out_ready = 1'b1;
        wait_idle(100);
        check("overflow_sticky", K'(overflow), K'(1));

        // clr mid-DRAIN together with me_valid: back to IDLE, word ignored.
        out_ready = 1'b0;
        send_burst(0, 1'b0, 1'b0);
        sb_q.delete();
        clr       = 1'b1;
        me_valid  = 1'b1;
        me_result = K'(16'hDEAD);
        step();
        clr       = 1'b0;
        me_valid  = 1'b0;
        me_result = '0;
        check("clr_overflow", K'(overflow), '0);
        check("clr_busy", K'(busy), '0);
        check("clr_valid", K'(out_valid), '0);
        out_ready = 1'b1;
        step();
        check("clr_still_idle", K'(busy), '0);

        // Asynchronous reset after 15 words of FILL, then a clean burst.
        for (int i = 0; i < 15; i++) send_word(K'(100 + i));
        check("fill_busy", K'(busy), K'(1));
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midfill_reset");
        step();
        rst_n = 1'b1;
        step();
        send_burst(0, 1'b0, 1'b1);
        wait_idle(100);
        check("sb_empty_end", K'(sb_q.size()), '0);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/me_result_collector.md
ME_RESULT_COLLECTOR -- requirements
Module: me_result_collector

Interface
REQ-001 SHALL have parameter K, default 128, word width in bits.
REQ-002 SHALL have parameter N, default 32, words per result (K*N = 4096-bit result).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clr  input  1  synchronous soft clear.
REQ-006 SHALL have port me_result  input  K  result word from the Montgomery exponentiation core, least-significant word first.
REQ-007 SHALL have port me_valid  input  1  qualifies me_result for one word per cycle.
REQ-008 SHALL have port out_data  output  K  buffered result word.
REQ-009 SHALL have port out_valid  output  1  out_data valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts word.
REQ-011 SHALL have port out_last  output  1  marks word N-1.
REQ-012 SHALL have port out_idx  output  $clog2(N)  index of current out_data word.
REQ-013 SHALL have port busy  output  1  high in FILL or DRAIN.
REQ-014 SHALL have port overflow  output  1  sticky: input word dropped.

Function
REQ-015 SHALL implement FSM states IDLE, FILL, DRAIN.
REQ-016 SHALL, in IDLE with me_valid=1, write me_result to buffer[0], set wr_idx=1, go to FILL.
REQ-017 SHALL, in FILL, write each me_valid word to buffer[wr_idx] and increment wr_idx; gaps (me_valid=0) hold state, no timeout.
REQ-018 SHALL, on the word written at wr_idx=N-1, go to DRAIN with rd_idx=0; N=1 goes IDLE->DRAIN directly.
REQ-019 SHALL assert out_valid exactly while in DRAIN; first out_valid the cycle after the N-th word is captured (latency 1).
REQ-020 SHALL drive out_data=buffer[rd_idx], out_idx=rd_idx, out_last=(rd_idx==N-1) while out_valid.
REQ-021 SHALL hold out_data, out_idx, out_last stable while out_valid=1 and out_ready=0.
REQ-022 SHALL advance rd_idx on out_valid&out_ready; on the handshake with out_last=1 return to IDLE.
REQ-023 SHALL, on me_valid=1 in DRAIN (including the final-handshake cycle), discard the word and set overflow; buffer contents unaffected.
REQ-024 SHALL keep overflow set until reset or clr.
REQ-025 SHALL, on clr=1, go to IDLE, zero wr_idx/rd_idx, clear overflow, ignore me_valid that cycle; clr has priority over all other events.
REQ-026 SHALL drive out_data=0 and out_last=0 when out_valid=0.
REQ-027 SHALL assert busy = (state != IDLE).

Reset
REQ-028 SHALL, on rst_n=0 at any time (including mid-FILL/DRAIN), force IDLE, wr_idx=0, rd_idx=0, out_valid=0, out_last=0, out_idx=0, out_data=0, busy=0, overflow=0.
REQ-029 SHALL not require buffer contents to be reset.

Structure
REQ-030 SHALL take K, N defaults and the state enum from shared package me_pkg.
REQ-031 SHALL place storage in one sub-module me_word_buf (N x K, one write port, one asynchronous read port).

Verification
REQ-032 SHALL cover: 32 consecutive words value i+1 (i=0..31), out_ready=1 -> out_valid one cycle after word 31, words 1..32 in order, out_last only with out_data=32, busy low after.
REQ-033 SHALL cover: 4096-bit result streamed LSW first, reassembled from out_data -> equals injected value bit-for-bit.
REQ-034 SHALL cover: me_valid with 1-cycle gaps between every word -> same output as REQ-032, no overflow.
REQ-035 SHALL cover: out_ready=0 for 10 cycles then toggling -> out_data/out_idx stable while stalled, 32 handshakes total.
REQ-036 SHALL cover: me_valid=1 with value 0xDEAD during DRAIN -> overflow=1, drained data unchanged; clr -> overflow=0, IDLE.
REQ-037 SHALL cover: rst_n low after 15 words in FILL -> all outputs zero; next 32-word burst collected correctly from index 0.
